// File: rtl/fifo_store4_8.sv
// Four-entry, 8-bit first-word-fall-through store feeding mux4_8.
// Slots drive d0..d3 directly and the read pointer drives the mux sel.
module fifo_store4_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       rd_en,
    output logic [7:0] d0,
    output logic [7:0] d1,
    output logic [7:0] d2,
    output logic [7:0] d3,
    output logic [1:0] sel,
    output logic [2:0] count,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       underflow
);

    logic [7:0] slot [4];
    logic [1:0] wp;
    logic       wa;
    logic       ra;
    logic [2:0] count_next;

    // wr_en/rd_en are requests sampled on the rising edge.
    // A request is accepted (wa/ra) only if the store can honour it that cycle.
    // A read when full frees a slot, so a simultaneous write is accepted.
    // A write into an empty store is not readable until the next cycle.
    always_comb begin
        wa = wr_en & (~full | rd_en);
        ra = rd_en & ~empty;
        count_next = count + {2'b00, wa} - {2'b00, ra};
    end

    always_comb begin
        empty = (count == 3'd0);
        full  = (count == 3'd4);
    end

    // Pointers, occupancy and error flags; clr wins over any request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= 2'd0;
            sel       <= 2'd0;
            count     <= 3'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wp        <= 2'd0;
            sel       <= 2'd0;
            count     <= 3'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wa) begin
                wp <= wp + 2'd1;
            end
            if (ra) begin
                sel <= sel + 2'd1;
            end
            count     <= count_next;
            overflow  <= wr_en & ~wa;
            underflow <= rd_en & ~ra;
        end
    end

    // Slot data is kept across clr; only reset wipes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot[i] <= 8'h00;
            end
        end else if (!clr && wa) begin
            slot[wp] <= din;
        end
    end

    always_comb begin
        d0 = slot[0];
        d1 = slot[1];
        d2 = slot[2];
        d3 = slot[3];
    end

endmodule

// File: tb/tb_fifo_store4_8.sv
// Self-checking bench for fifo_store4_8: queue-based reference model compared
// every cycle, plus directed hand-computed checks on the test-plan scenarios.
module tb_fifo_store4_8;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] d0, d1, d2, d3;
    logic [1:0] sel;
    logic [2:0] count;
    logic       empty, full, overflow, underflow;

    int n_cmp;
    int n_bad;

    fifo_store4_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .wr_en     (wr_en),
        .din       (din),
        .rd_en     (rd_en),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .sel       (sel),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: stored bytes in arrival order, slot image, op totals
    logic [7:0] exp_q [$];
    logic [7:0] m_slot [4];
    int         m_reads;
    int         m_writes;
    logic       m_ovf;
    logic       m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
            m_reads  = 0;
            m_writes = 0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else if (clr) begin
            exp_q.delete();
            m_reads  = 0;
            m_writes = 0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            bit w_ok, r_ok;
            r_ok = rd_en && (exp_q.size() > 0);
            w_ok = wr_en && ((exp_q.size() < 4) || rd_en);
            if (r_ok) begin
                void'(exp_q.pop_front());
                m_reads++;
            end
            if (w_ok) begin
                exp_q.push_back(din);
                m_slot[m_writes % 4] = din;
                m_writes++;
            end
            m_ovf = wr_en && !w_ok;
            m_unf = rd_en && !r_ok;
        end
    end

    function automatic logic [7:0] mux_out();
        case (sel)
            2'd0: return d0;
            2'd1: return d1;
            2'd2: return d2;
            default: return d3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_count", 32'(count), 32'(exp_q.size()));
            check("m_empty", 32'(empty), 32'(exp_q.size() == 0));
            check("m_full", 32'(full), 32'(exp_q.size() == 4));
            check("m_sel", 32'(sel), 32'(m_reads % 4));
            check("m_ovf", 32'(overflow), 32'(m_ovf));
            check("m_unf", 32'(underflow), 32'(m_unf));
            check("m_d0", 32'(d0), 32'(m_slot[0]));
            check("m_d1", 32'(d1), 32'(m_slot[1]));
            check("m_d2", 32'(d2), 32'(m_slot[2]));
            check("m_d3", 32'(d3), 32'(m_slot[3]));
            if (exp_q.size() > 0) check("m_mux", 32'(mux_out()), 32'(exp_q[0]));
        end
    end

    // driver: apply inputs for one edge, return 1 time unit after it
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en = w;
        din   = d;
        rd_en = r;
        clr   = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    logic [7:0] fill_v [4];
    logic [7:0] wrap_v [10];
    logic [7:0] snap [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        fill_v = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        wrap_v = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hA9};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_d", 32'({d0, d1, d2, d3}), 32'h0);
        check("rst_flags", 32'({overflow, underflow, full}), 32'd0);

        // fill and drain
        for (int i = 0; i < 4; i++) cyc(1'b1, fill_v[i], 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        check("fill_d0", 32'(d0), 32'hA1);
        check("fill_d3", 32'(d3), 32'hD4);
        for (int i = 0; i < 4; i++) begin
            check("drain_sel", 32'(sel), 32'(i));
            check("drain_mux", 32'(mux_out()), 32'(fill_v[i]));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_sel_end", 32'(sel), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);

        // underflow with simultaneous write into empty store
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd1);
        check("unf_sel", 32'(sel), 32'd0);
        check("unf_mux", 32'(mux_out()), 32'h77);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("unf_clear", 32'(underflow), 32'd0);

        // refill, then overflow
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        check("ovf_prefull", 32'(full), 32'd1);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_data", 32'({d0, d1, d2, d3}), 32'h77112233);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_once", 32'(overflow), 32'd0);
        cyc(1'b1, 8'h66, 1'b1, 1'b0);
        check("full_rw_count", 32'(count), 32'd4);
        check("full_rw_d0", 32'(d0), 32'h66);
        check("full_rw_ovf", 32'(overflow), 32'd0);
        check("full_rw_mux", 32'(mux_out()), 32'h11);

        // down to two entries, then sustained read+write through wrap
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap_start", 32'(count), 32'd2);
        check("wrap_head", 32'(mux_out()), 32'h33);
        for (int i = 0; i < 10; i++) cyc(1'b1, wrap_v[i], 1'b1, 1'b0);
        check("wrap_count", 32'(count), 32'd2);
        check("wrap_mux", 32'(mux_out()), 32'h98);
        check("wrap_sel", 32'(sel), 32'd1);

        // clear at count 3 with both requests
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        check("clr_pre", 32'(count), 32'd3);
        snap = '{d0, d1, d2, d3};
        cyc(1'b1, 8'h5A, 1'b1, 1'b1);
        check("clr_count", 32'(count), 32'd0);
        check("clr_sel", 32'(sel), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);
        check("clr_flags", 32'({overflow, underflow}), 32'd0);
        check("clr_data", 32'({d0, d1, d2, d3}), 32'({snap[0], snap[1], snap[2], snap[3]}));

        // asynchronous reset mid-stream
        cyc(1'b1, 8'hC1, 1'b0, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0, 1'b0);
        wr_en = 1'b1;
        din   = 8'hC3;
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_d", 32'({d0, d1, d2, d3}), 32'h0);
        check("arst_empty", 32'(empty), 32'd1);
        wr_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 8'h9F, 1'b0, 1'b0);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_d0", 32'(d0), 32'h9F);
        check("post_rst_mux", 32'(mux_out()), 32'h9F);
        repeat (2) @(posedge clk);

        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_store4_8.md
# fifo_store4_8

Four-entry, 8-bit first-in/first-out storage stage that sits directly upstream of the 4:1 byte multiplexer `mux4_8` in the data storage system. The block holds the four storage slots and drives them onto the mux data inputs `d0`..`d3`. It also drives the mux `sel` input with its read pointer, so the mux output is always the oldest stored byte (first-word fall-through). The block manages write/read acceptance, occupancy and error flags.

## Interface
- No parameters. Depth is fixed at 4 and width at 8, matching the `mux4_8` inputs.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of pointers and occupancy.
- `wr_en`  in  1  write request; `din` is sampled on the same edge.
- `din`  in  8  write data.
- `rd_en`  in  1  read (pop) request for the byte currently selected by `sel`.
- `d0`, `d1`, `d2`, `d3`  out  8 each  storage slots 0..3, registered, wired to the mux inputs of the same name.
- `sel`  out  2  read pointer, wired to the mux `sel`.
- `count`  out  3  number of stored bytes, 0..4.
- `empty`  out  1  high when `count == 0`.
- `full`  out  1  high when `count == 4`.
- `overflow`  out  1  one-cycle pulse: a write was rejected.
- `underflow`  out  1  one-cycle pulse: a read was rejected.

## Operation
- State:
  - four 8-bit slots;
  - 2-bit write pointer `wp` (internal);
  - 2-bit read pointer `sel`;
  - 3-bit `count`.
- `empty` and `full` are decoded combinationally from `count`.
- Write acceptance: `wa = wr_en & (~full | rd_en)`. When full, a simultaneous read frees a slot, so the write is accepted.
- Read acceptance: `ra = rd_en & ~empty`. When empty, a simultaneous write is accepted but the read is rejected, because the byte is not yet visible.
- On `wa`:
  - slot[`wp`] <= `din`;
  - `wp` <= `wp + 1` modulo 4 (3 wraps to 0).
- On `ra`: `sel` <= `sel + 1` modulo 4. Slot contents are not modified by a read.
- Count update:
  - `count` <= `count + wa - ra`;
  - range always 0..4;
  - `wa & ra` leaves `count` unchanged.
- Error flags:
  - `overflow` <= `wr_en & ~wa`;
  - `underflow` <= `rd_en & ~ra`.
- `clr` has priority over `wr_en` and `rd_en`:
  - `wp`, `sel`, `count` <= 0;
  - `overflow`, `underflow` <= 0;
  - slot contents are retained.
- Downstream contract: the mux output equals slot[`sel`], which is the oldest byte whenever `empty` is 0. It is don't-care when empty.

## Timing
- Reset (asynchronous assert, takes effect immediately): `d0`..`d3` = 8'h00, `sel` = 0, `wp` = 0, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0.
- Reset mid-operation discards all data and pointers; the first edge after deassertion behaves as from empty.
- Write latency: `din` appears on slot[`wp`] one cycle after the accepting edge. A write into an empty FIFO is visible at the mux output one cycle after the write edge.
- Read latency: `sel` advances one cycle after the accepting edge. The next byte is at the mux output in that same cycle.
- `count`, `full` and `empty` reflect the edge's accepted operations from the following cycle.
- `overflow` and `underflow` are high for exactly the one cycle following the offending edge.
- Sustained throughput: one write and one read per cycle at any occupancy from 1 to 4.

## Test plan
- Reset: hold `rst_n` = 0 mid-stream, then release. Required: `count` = 0, `empty` = 1, `sel` = 0, `d0`..`d3` = 00, no flags set.
- Fill and drain:
  - write A1, B2, C3, D4 on consecutive cycles. Required: `full` = 1, `count` = 4, `d0` = A1, `d3` = D4.
  - then pop 4 times. Required: mux output A1, B2, C3, D4; `sel` steps 0→1→2→3→0; `empty` = 1 at the end.
- Overflow: when full, write 55 with `rd_en` = 0. Required: `overflow` pulses for 1 cycle; contents and `count` (4) unchanged. Then write 66 with `rd_en` = 1. Required: accepted, `count` stays 4, 66 lands in the slot just freed.
- Underflow: when empty, assert `rd_en` and `wr_en` with `din` = 77. Required: `underflow` pulses; `count` = 1; `sel` = 0; output = 77 on the next cycle.
- Wrap-around: 10 cycles of write and read together, starting at `count` = 2. Required: both pointers wrap past 3; `count` stays 2; output order matches input order.
- Clear: at `count` = 3, assert `clr` together with `wr_en` and `rd_en`. Required: next cycle `count` = 0, `sel` = 0, `empty` = 1, no flags set, slot data unchanged.
